// File: rtl/iir_pkg.sv
// Shared types for the IIR output power meter: sample/power widths and window FSM.
package iir_pkg;
   localparam int Ndwidth = 18;
   localparam int PW      = 2 * Ndwidth;

   typedef logic signed [Ndwidth-1:0] samp_t;
   typedef logic [PW-1:0]             pwr_t;
   typedef logic [PW-2:0]             sq_t;

   typedef enum logic {
      ST_RUN   = 1'b0,
      ST_FLUSH = 1'b1
   } win_st_t;

   // |x| as an unsigned Ndwidth value; -2^(Ndwidth-1) maps to 2^(Ndwidth-1) exactly.
   function automatic logic [Ndwidth-1:0] mag(input samp_t x);
      return x[Ndwidth-1] ? $unsigned(-x) : $unsigned(x);
   endfunction

   function automatic pwr_t pmax(input pwr_t a, input pwr_t b);
      return (a > b) ? a : b;
   endfunction
endpackage

// File: rtl/iir_power_meter_mag_sq.sv
// Two-stage |y|^2 pipeline: registered squares, then registered full-precision sum.
module mag_sq
   import iir_pkg::*;
(
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      i_flush,
   input  logic                      i_vld,
   input  logic signed [Ndwidth-1:0] i_re,
   input  logic signed [Ndwidth-1:0] i_im,
   output logic                      o_vld,
   output logic [PW-1:0]             o_sum
);
   logic [Ndwidth-1:0] w_re_mag;
   logic [Ndwidth-1:0] w_im_mag;
   sq_t                w_re_sq;
   sq_t                w_im_sq;
   logic               r_sq_vld;
   sq_t                r_re_sq;
   sq_t                r_im_sq;

   // Squaring the magnitude keeps the product unsigned and PW-1 bits wide.
   assign w_re_mag = mag(i_re);
   assign w_im_mag = mag(i_im);
   assign w_re_sq  = sq_t'(w_re_mag) * sq_t'(w_re_mag);
   assign w_im_sq  = sq_t'(w_im_mag) * sq_t'(w_im_mag);

   always_ff @(posedge clk) begin
      if (rst || i_flush) begin
         r_sq_vld <= 1'b0;
         o_vld    <= 1'b0;
      end else begin
         r_sq_vld <= i_vld;
         o_vld    <= r_sq_vld;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_re_sq <= '0;
         r_im_sq <= '0;
         o_sum   <= '0;
      end else begin
         if (i_vld) begin
            r_re_sq <= w_re_sq;
            r_im_sq <= w_im_sq;
         end
         if (r_sq_vld) o_sum <= pwr_t'(r_re_sq) + pwr_t'(r_im_sq);
      end
   end
endmodule

// File: rtl/iir_power_meter.sv
// Pairs real/imag filter outputs, forms |y|^2 and reports mean and peak per 2^LOG2N pairs.
module iir_power_meter
   import iir_pkg::*;
#(
   parameter int LOG2N = 10
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      en,
   input  logic                      dv_real,
   input  logic signed [Ndwidth-1:0] d_real,
   input  logic                      dv_imag,
   input  logic signed [Ndwidth-1:0] d_imag,
   output logic                      dv_out,
   output logic [2*Ndwidth-1:0]      pwr_out,
   output logic [2*Ndwidth-1:0]      peak_out,
   output logic                      err_unpaired
);
   localparam int AW = PW + LOG2N;

   samp_t            r_hr;
   samp_t            r_hi;
   logic             r_hr_vld;
   logic             r_hi_vld;
   logic             w_pair;
   samp_t            w_pr;
   samp_t            w_pi;
   logic             w_drop;

   win_st_t          r_state;
   win_st_t          w_state_nx;
   logic             w_flush;
   logic             w_pipe_kill;

   logic             w_sum_vld;
   pwr_t             w_sum;
   logic [AW-1:0]    r_acc;
   logic [AW-1:0]    w_acc_sum;
   pwr_t             r_peak;
   logic [LOG2N-1:0] r_cnt;

   // Held sample is older than a live one, so it is consumed first.
   always_comb begin
      w_pair = en & (dv_real | r_hr_vld) & (dv_imag | r_hi_vld);
      w_pr   = r_hr_vld ? r_hr : d_real;
      w_pi   = r_hi_vld ? r_hi : d_imag;
      w_drop = ~w_pair & ((dv_real & r_hr_vld) | (dv_imag & r_hi_vld));
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_hr         <= '0;
         r_hi         <= '0;
         r_hr_vld     <= 1'b0;
         r_hi_vld     <= 1'b0;
         err_unpaired <= 1'b0;
      end else if (!en) begin
         r_hr_vld <= 1'b0;
         r_hi_vld <= 1'b0;
      end else begin
         if (dv_real) r_hr <= d_real;
         if (dv_imag) r_hi <= d_imag;
         r_hr_vld <= w_pair ? (r_hr_vld & dv_real) : (r_hr_vld | dv_real);
         r_hi_vld <= w_pair ? (r_hi_vld & dv_imag) : (r_hi_vld | dv_imag);
         if (w_drop) err_unpaired <= 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) r_state <= ST_RUN;
      else     r_state <= w_state_nx;
   end

   always_comb begin
      w_state_nx = r_state;
      case (r_state)
         ST_RUN:   if (!en) w_state_nx = ST_FLUSH;
         ST_FLUSH: if (en)  w_state_nx = ST_RUN;
         default:  w_state_nx = ST_RUN;
      endcase
   end

   // Pipeline is killed only while en is low so the first pair after en rises survives.
   always_comb begin
      w_flush     = (r_state == ST_FLUSH) | ~en;
      w_pipe_kill = ~en;
   end

   mag_sq u_mag_sq (
      .clk     (clk),
      .rst     (rst),
      .i_flush (w_pipe_kill),
      .i_vld   (w_pair),
      .i_re    (w_pr),
      .i_im    (w_pi),
      .o_vld   (w_sum_vld),
      .o_sum   (w_sum)
   );

   assign w_acc_sum = r_acc + AW'(w_sum);

   always_ff @(posedge clk) begin
      if (rst) begin
         r_acc    <= '0;
         r_peak   <= '0;
         r_cnt    <= '0;
         dv_out   <= 1'b0;
         pwr_out  <= '0;
         peak_out <= '0;
      end else begin
         dv_out <= 1'b0;
         if (w_flush) begin
            r_acc  <= '0;
            r_peak <= '0;
            r_cnt  <= '0;
         end else if (w_sum_vld) begin
            if (&r_cnt) begin
               pwr_out  <= PW'(w_acc_sum >> LOG2N);
               peak_out <= pmax(r_peak, w_sum);
               dv_out   <= 1'b1;
               r_acc    <= '0;
               r_peak   <= '0;
               r_cnt    <= '0;
            end else begin
               r_acc  <= w_acc_sum;
               r_peak <= pmax(r_peak, w_sum);
               r_cnt  <= r_cnt + 1'b1;
            end
         end
      end
   end
endmodule

// File: tb/tb_iir_power_meter.sv
// Directed bench for iir_power_meter with a queue-based transaction model and literal window checks.
module tb_iir_power_meter;
   localparam int LOG2N = 4;
   localparam int N     = 1 << LOG2N;

   logic               clk;
   logic               rst;
   logic               en;
   logic               dv_real;
   logic signed [17:0] d_real;
   logic               dv_imag;
   logic signed [17:0] d_imag;
   logic               dv_out;
   logic [35:0]        pwr_out;
   logic [35:0]        peak_out;
   logic               err_unpaired;

   int n_chk = 0;
   int n_err = 0;

   iir_power_meter #(.LOG2N(LOG2N)) dut (
      .clk          (clk),
      .rst          (rst),
      .en           (en),
      .dv_real      (dv_real),
      .d_real       (d_real),
      .dv_imag      (dv_imag),
      .d_imag       (d_imag),
      .dv_out       (dv_out),
      .pwr_out      (pwr_out),
      .peak_out     (peak_out),
      .err_unpaired (err_unpaired)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         if (n_err < 30) $display("FAIL %s: got %0d expected %0d", nm, act, exp);
      end
   endtask

   // Model: per-channel pending queues; a pair's power lands in the window 2 cycles later,
   // and a completed window shows up on the outputs the cycle after that.
   typedef struct { longint p; int due; } pend_t;
   longint qr[$];
   longint qi[$];
   pend_t  pend[$];
   longint win[$];
   int     cyc = 0;
   bit     m_dv = 0;
   bit     m_err = 0;
   longint m_pwr = 0;
   longint m_peak = 0;

   always @(negedge clk) begin
      chk("dv_out",   {63'd0, dv_out},       {63'd0, m_dv});
      chk("pwr_out",  {28'd0, pwr_out},      m_pwr);
      chk("peak_out", {28'd0, peak_out},     m_peak);
      chk("err",      {63'd0, err_unpaired}, {63'd0, m_err});
      if (rst) begin
         qr.delete(); qi.delete(); pend.delete(); win.delete();
         m_dv = 0; m_err = 0; m_pwr = 0; m_peak = 0;
      end else begin
         m_dv = 0;
         if (!en) begin
            qr.delete(); qi.delete(); pend.delete(); win.delete();
         end else begin
            if (dv_real) qr.push_back(longint'(d_real));
            if (dv_imag) qi.push_back(longint'(d_imag));
            while (pend.size() > 0 && pend[0].due == cyc) begin
               win.push_back(pend[0].p);
               void'(pend.pop_front());
            end
            if (win.size() == N) begin
               longint s, mx;
               s = 0; mx = 0;
               foreach (win[j]) begin
                  s += win[j];
                  if (win[j] > mx) mx = win[j];
               end
               m_pwr = s >> LOG2N; m_peak = mx; m_dv = 1;
               win.delete();
            end
            if (qr.size() > 0 && qi.size() > 0) begin
               pend_t e;
               e.p = qr[0] * qr[0] + qi[0] * qi[0];
               e.due = cyc + 2;
               pend.push_back(e);
               void'(qr.pop_front()); void'(qi.pop_front());
            end
            if (qr.size() > 1) begin void'(qr.pop_front()); m_err = 1; end
            if (qi.size() > 1) begin void'(qi.pop_front()); m_err = 1; end
         end
      end
      cyc++;
   end

   longint cap_pwr[$];
   longint cap_peak[$];
   always @(negedge clk) if (dv_out === 1'b1) begin
      cap_pwr.push_back(longint'(pwr_out));
      cap_peak.push_back(longint'(peak_out));
   end

   task automatic drive(input bit r, input bit e, input bit dr, input int vr, input bit di, input int vi);
      @(posedge clk); #1;
      rst = r; en = e; dv_real = dr; d_real = 18'(vr); dv_imag = di; d_imag = 18'(vi);
   endtask

   task automatic idle(input int n);
      for (int k = 0; k < n; k++) drive(0, 1, 0, 0, 0, 0);
   endtask

   task automatic pairs(input int n, input int gap, input int vr, input int vi);
      for (int k = 0; k < n; k++) begin
         drive(0, 1, 1, vr, 1, vi);
         idle(gap - 1);
      end
   endtask

   task automatic chk_caps(input string nm, input int n, input longint pw, input longint pk);
      chk({nm, " windows"}, cap_pwr.size(), n);
      foreach (cap_pwr[j]) begin
         chk({nm, " pwr"},  cap_pwr[j],  pw);
         chk({nm, " peak"}, cap_peak[j], pk);
      end
      cap_pwr.delete(); cap_peak.delete();
   endtask

   initial begin
      rst = 1; en = 0; dv_real = 0; d_real = 0; dv_imag = 0; d_imag = 0;
      repeat (3) @(posedge clk);
      #1 rst = 0; en = 1;
      @(negedge clk);
      chk("reset pwr",  {28'd0, pwr_out},  64'd0);
      chk("reset peak", {28'd0, peak_out}, 64'd0);
      chk("reset dv",   {63'd0, dv_out},   64'd0);
      chk("reset err",  {63'd0, err_unpaired}, 64'd0);

      // 1: amplitude 1000 on both channels, a pair every 7th cycle
      pairs(N, 7, 1000, 1000); idle(6);
      chk_caps("t1", 1, 2000000, 2000000);

      // 2: full-scale negative, no wrap
      pairs(N, 3, -131072, -131072); idle(6);
      chk_caps("t2", 1, 64'd34359738368, 64'd34359738368);

      // 3a: imag always one cycle behind real
      for (int k = 0; k < N; k++) begin
         drive(0, 1, 1, 600, 0, 0);
         drive(0, 1, 0, 0, 1, 800);
         idle(2);
      end
      idle(6);
      chk_caps("t3a", 1, 1000000, 1000000);
      chk("t3a err", {63'd0, err_unpaired}, 64'd0);

      // 3b: second real overwrites the first, which must not reach the window
      drive(0, 1, 1, 30000, 0, 0); idle(1);
      drive(0, 1, 1, 100, 0, 0);   idle(1);
      drive(0, 1, 0, 0, 1, 100);   idle(2);
      pairs(N - 1, 3, 100, 100); idle(6);
      chk_caps("t3b", 1, 20000, 20000);
      chk("t3b err", {63'd0, err_unpaired}, 64'd1);

      // 4: partial window abandoned by en=0, then a fresh window
      pairs(7, 3, 1000, 1000); idle(4);
      for (int k = 0; k < 5; k++) drive(0, 0, 0, 0, 0, 0);
      pairs(N, 3, 100, 100); idle(6);
      chk_caps("t4", 1, 20000, 20000);

      // 5: rst two cycles after the final pair suppresses the result
      pairs(N - 1, 2, 500, 500);
      drive(0, 1, 1, 500, 1, 500);
      idle(1);
      drive(1, 1, 0, 0, 0, 0);
      drive(0, 1, 0, 0, 0, 0);
      @(negedge clk);
      chk("t5 pwr",  {28'd0, pwr_out},  64'd0);
      chk("t5 peak", {28'd0, peak_out}, 64'd0);
      chk("t5 err",  {63'd0, err_unpaired}, 64'd0);
      idle(6);
      chk_caps("t5", 0, 0, 0);

      // 6: back-to-back windows, alternating 0 / 1000 amplitude every cycle
      for (int k = 0; k < 4 * N; k++) begin
         int v;
         v = (k % 2 == 1) ? 1000 : 0;
         drive(0, 1, 1, v, 1, v);
      end
      idle(6);
      chk_caps("t6", 4, 1000000, 2000000);

      idle(4);
      $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
      $finish;
   end
endmodule
